// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: request handshake, sample-ROM and audio-controller signals of the sound sequencer.
interface sound_sequencer_if #(
    parameter int ADDR_W   = 18,
    parameter int SAMPLE_W = 6
);
    logic                req_valid;
    logic [1:0]          req_id;
    logic                req_loop;
    logic                stop;
    logic                req_ready;
    logic [ADDR_W-1:0]   rom_addr;
    logic [SAMPLE_W-1:0] rom_q;
    logic                audio_out_allowed;
    logic                write_audio_out;
    logic [31:0]         left_channel_audio_out;
    logic [31:0]         right_channel_audio_out;
    logic                busy;
    logic                done;
    logic [7:0]          overrun_cnt;

    modport master (
        output req_valid, req_id, req_loop, stop, rom_q, audio_out_allowed,
        input  req_ready, rom_addr, write_audio_out, left_channel_audio_out,
               right_channel_audio_out, busy, done, overrun_cnt
    );

    modport slave (
        input  req_valid, req_id, req_loop, stop, rom_q, audio_out_allowed,
        output req_ready, rom_addr, write_audio_out, left_channel_audio_out,
               right_channel_audio_out, busy, done, overrun_cnt
    );
endinterface

// File: rtl/sound_sequencer.sv
// sound_sequencer: walks a ROM segment per sound request at one sample every DIV clocks and feeds the audio controller.
module sound_sequencer #(
    parameter int ADDR_W       = 18,
    parameter int SAMPLE_W     = 6,
    parameter int DIV          = 1200,
    parameter int WIN_START    = 0,
    parameter int WIN_END      = 16395,
    parameter int MOO_START    = 16396,
    parameter int MOO_END      = 66982,
    parameter int DETECT_START = 66983,
    parameter int DETECT_END   = 83254,
    parameter int CHEER_START  = 83255,
    parameter int CHEER_END    = 137138
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    sound_sequencer_if.slave bus
);
    localparam int TW = $clog2(DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                loop_q, loop_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                pending_q, pending_d;
    logic                done_q, done_d;
    logic [7:0]          ovr_q, ovr_d;

    logic accept;
    logic latch;
    logic write;
    logic last;

    function automatic logic [ADDR_W-1:0] seg_start(input logic [1:0] id);
        return id == 2'd0 ? ADDR_W'(WIN_START) : id == 2'd1 ? ADDR_W'(MOO_START) :
               id == 2'd2 ? ADDR_W'(DETECT_START) : ADDR_W'(CHEER_START);
    endfunction

    function automatic logic [ADDR_W-1:0] seg_end(input logic [1:0] id);
        return id == 2'd0 ? ADDR_W'(WIN_END) : id == 2'd1 ? ADDR_W'(MOO_END) :
               id == 2'd2 ? ADDR_W'(DETECT_END) : ADDR_W'(CHEER_END);
    endfunction

    // stop outranks a request, and a request outranks the sample latch so a restart never counts as overrun
    assign accept = bus.req_valid & ~bus.stop;
    assign latch  = state_q == PLAY && tick_q == TICK_MAX && !bus.stop && !bus.req_valid;
    assign write  = pending_q & bus.audio_out_allowed;
    assign last   = addr_q == end_q && !loop_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = bus.stop ? IDLE :
                  accept ? PLAY :
                  (latch && last) ? DRAIN :
                  (state_q == DRAIN && !pending_q) ? IDLE : state_q;
    end

    always_comb begin
        bus.req_ready               = ~bus.stop;
        bus.rom_addr                = addr_q;
        bus.write_audio_out         = write;
        bus.left_channel_audio_out  = {sample_q, {(32 - SAMPLE_W){1'b0}}};
        bus.right_channel_audio_out = '0;
        bus.busy                    = state_q != IDLE;
        bus.done                    = done_q;
        bus.overrun_cnt             = ovr_q;
    end

    always_comb begin
        start_d   = accept ? seg_start(bus.req_id) : start_q;
        end_d     = accept ? seg_end(bus.req_id) : end_q;
        loop_d    = accept ? bus.req_loop : loop_q;
        addr_d    = accept ? seg_start(bus.req_id) :
                    !latch ? addr_q :
                    addr_q != end_q ? addr_q + 1'b1 :
                    loop_q ? start_q : addr_q;
        tick_d    = (bus.stop || accept) ? '0 :
                    state_q != PLAY ? tick_q :
                    tick_q == TICK_MAX ? '0 : tick_q + 1'b1;
        sample_d  = latch ? bus.rom_q : sample_q;
        pending_d = (bus.stop || accept) ? 1'b0 : latch ? 1'b1 : write ? 1'b0 : pending_q;
        ovr_d     = (latch && pending_q && !write && ovr_q != 8'hff) ? ovr_q + 8'd1 : ovr_q;
        done_d    = state_q == DRAIN && !pending_q && !bus.stop && !bus.req_valid;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            start_q   <= '0;
            end_q     <= '0;
            loop_q    <= 1'b0;
            tick_q    <= '0;
            sample_q  <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            start_q   <= start_d;
            end_q     <= end_d;
            loop_q    <= loop_d;
            tick_q    <= tick_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed and random requests checked cycle by cycle against a sample-schedule model.
module tb_sound_sequencer;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sound_sequencer_if #(.ADDR_W(18), .SAMPLE_W(6)) bus ();

    sound_sequencer #(
        .ADDR_W(18), .SAMPLE_W(6), .DIV(DIV),
        .WIN_START(0), .WIN_END(3), .MOO_START(4), .MOO_END(5),
        .DETECT_START(6), .DETECT_END(6), .CHEER_START(7), .CHEER_END(9)
    ) dut (
        .CLOCK_50(clk),
        .resetn(rst_n),
        .bus(bus)
    );

    logic [5:0] rom_mem [16];
    always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr[3:0]];

    int lo_t [4] = '{0, 4, 6, 7};
    int hi_t [4] = '{3, 5, 6, 9};

    // model: a sound is a segment plus an absolute edge number at which the next sample is due
    int       e = 0;
    bit       m_busy, m_drain, m_pend, m_loop, m_done, m_wr;
    int       m_lo, m_hi, m_addr, m_next, m_ovr;
    bit [5:0] m_sample;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_drain = 0; m_pend = 0; m_done = 0;
            m_addr = 0; m_ovr = 0; m_sample = 0;
        end else begin
            m_wr = m_pend && bus.audio_out_allowed;
            m_done = 0;
            if (bus.stop) begin
                m_busy = 0; m_drain = 0; m_pend = 0;
            end else if (bus.req_valid) begin
                m_busy = 1; m_drain = 0; m_pend = 0;
                m_lo = lo_t[bus.req_id]; m_hi = hi_t[bus.req_id]; m_loop = bus.req_loop;
                m_addr = m_lo; m_next = e + DIV;
            end else if (m_busy && !m_drain && e == m_next) begin
                if (m_pend && !m_wr && m_ovr < 255) m_ovr++;
                m_sample = rom_mem[m_addr];
                m_pend = 1;
                m_next = e + DIV;
                if (m_addr != m_hi) m_addr++;
                else if (m_loop) m_addr = m_lo;
                else m_drain = 1;
            end else begin
                if (m_drain && !m_pend) begin
                    m_done = 1; m_busy = 0; m_drain = 0;
                end
                if (m_wr) m_pend = 0;
            end
            e++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("req_ready", 32'(bus.req_ready), 32'(!bus.stop));
        check("write", 32'(bus.write_audio_out), 32'(m_pend && bus.audio_out_allowed));
        check("left", bus.left_channel_audio_out, {m_sample, 26'b0});
        check("right", bus.right_channel_audio_out, 32'd0);
        check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("done", 32'(bus.done), 32'(m_done));
        check("overrun", 32'(bus.overrun_cnt), 32'(m_ovr));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic req(input logic [1:0] id, input logic lp);
        bus.req_valid = 1'b1; bus.req_id = id; bus.req_loop = lp;
        run(1);
        bus.req_valid = 1'b0;
    endtask

    int pct = 100;

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = 6'($urandom);
        bus.req_valid = 0; bus.req_id = 0; bus.req_loop = 0; bus.stop = 0;
        bus.audio_out_allowed = 1;
        #2 rst_n = 1'b0;
        #1 check_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(2);
        req(2'd0, 1'b0); run(30);
        req(2'd2, 1'b0); run(15);
        req(2'd1, 1'b1); run(80);
        bus.stop = 1; run(1); bus.stop = 0; run(10);
        req(2'd3, 1'b1); run(6);
        bus.audio_out_allowed = 0; run(9);
        bus.audio_out_allowed = 1; run(10);
        bus.stop = 1; run(1); bus.stop = 0; run(3);
        req(2'd0, 1'b0); run(6);
        bus.req_valid = 1; bus.req_id = 2'd3; bus.stop = 1; run(1);
        bus.stop = 0; run(1);
        bus.req_valid = 0; run(40);
        req(2'd3, 1'b1); run(9);
        #2 rst_n = 1'b0;
        #1 check_all();
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) pct = $urandom_range(0, 2) == 0 ? 10 : $urandom_range(0, 1) ? 70 : 100;
            bus.req_valid = $urandom_range(0, 59) == 0;
            bus.req_id = 2'($urandom);
            bus.req_loop = 1'($urandom);
            bus.stop = $urandom_range(0, 199) == 0;
            bus.audio_out_allowed = $urandom_range(0, 99) < pct;
            run(1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
